reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised successor of the single `register` block: a multi-entry register file for the sword4 core datapath.
- 2 combinational read ports, 1 byte-maskable write port, write-to-read bypass.
- Per-entry pending scoreboard: issue logic sets an entry's pending bit; the matching writeback clears it.
- Sits between decode/issue (reads, busy checks) and writeback (writes).

Parameters:
- WIDTH, 32, data width in bits. Must be a multiple of 8. Default matches Global::size_t.
- DEPTH, 32, number of entries. Must be a power of 2, at least 2.
- ZERO_REG, 1, when 1, entry 0 reads as 0, ignores writes and is never pending.
- AW, $clog2(DEPTH), address width. Derived; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ra1  in  AW  read port 1 address.
- rd1  out  WIDTH  read port 1 data.
- busy1  out  1  entry ra1 is pending.
- ra2  in  AW  read port 2 address.
- rd2  out  WIDTH  read port 2 data.
- busy2  out  1  entry ra2 is pending.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  WIDTH  write data.
- wbe  in  WIDTH/8  byte enables; bit i covers wd[8i+7:8i].
- issue_en  in  1  mark issue_addr pending.
- issue_addr  in  AW  destination being issued.
- pending_cnt  out  AW+1  number of pending entries (registered).

Behaviour:
- Reset (async assert, applies at any time, including mid-operation): all entries = 0, all pending bits = 0, pending_cnt = 0. rd1/rd2 then show 0; busy1/busy2 show 0.
- Write (rising edge, we=1): entry[wa] byte i <= wd byte i where wbe[i]=1; other bytes keep their value. we=1 with wbe=0 changes no data but still clears pending.
- Read (combinational):
  - rd1 = entry[ra1], except when we=1 && wa==ra1, in which case rd1 = the merged value (wd bytes where wbe=1, old bytes elsewhere).
  - Same rule for rd2.
  - Read latency is therefore 0 cycles; a write is visible on the same cycle's read port.
- ZERO_REG=1:
  - Any read of address 0 returns 0, including during a bypassed write to 0.
  - Writes to 0 are discarded.
  - issue_en to 0 is ignored.
- Scoreboard (rising edge):
  - issue_en=1 sets pending[issue_addr].
  - we=1 clears pending[wa].
  - issue_en and we to the same address in the same cycle: pending ends 1 (the new producer wins).
  - Issue to an already pending entry: the bit stays 1 and pending_cnt does not change.
- busy1 = pending[ra1] & ~(we && wa==ra1); busy2 likewise. This is the clear-bypass: the writeback cycle is not busy.
  - A same-cycle issue to ra1 does not assert busy1 until the next cycle.
- pending_cnt: registered popcount of the pending bits, updated on the same edge as the bits. Range 0..DEPTH (0..DEPTH-1 when ZERO_REG=1).
- Out-of-range addresses cannot occur, because DEPTH is a power of 2.
- No X propagation from unwritten entries: every entry is defined by reset.

Decomposition:
- Package Global: size_t (existing, WIDTH=32), typedef reg_addr_t = logic[4:0], typedef byte_en_t = logic[3:0].
- Parametrised instances use local parameters; the defaults tie back to Global.
- One sub-module: rf_scoreboard. It holds the pending bits, the set/clear priority and pending_cnt, and outputs the pending vector.
- Storage, byte merge and bypass stay in reg_file_sb.

Test Plan:
- rst=1, then released; read all addresses → rd1=rd2=0, busy1=busy2=0, pending_cnt=0.
- we=1, wa=5, wd=32'haaaabbbb, wbe=4'hF, ra1=5 in the same cycle → rd1=32'haaaabbbb in that cycle (bypass). Next cycle with we=0 → rd1 still 32'haaaabbbb.
- Entry 5 = 32'haaaabbbb; write wd=32'h11223344 with wbe=4'b0101 → entry 5 reads 32'haa22bb44.
- issue_en=1, issue_addr=7 → busy1=1 at ra1=7 on the next cycle, pending_cnt=1. Then we=1, wa=7 → busy1=0 in that same cycle; after the edge pending_cnt=0.
- issue_en=1 and we=1 both to address 9 in the same cycle → afterwards busy=1 for 9 and pending_cnt=1. Write to 0 with wd=32'hffffffff plus issue to 0 → rd of 0 = 0, busy=0, pending_cnt unchanged.
- Issue 3, 4, 6 on consecutive cycles (pending_cnt=3), then assert rst asynchronously mid-cycle → pending_cnt=0, busy=0 and all entries 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/Global.sv
// Shared sword4 datapath types and sizes.
// Holds the core data width and the default register-file address and byte-enable types.
// Ports: none (package only).
package Global;

    // Native datapath width of the sword4 core, in bits.
    localparam int unsigned size_t = 32;

    // Default register-file address (32 entries) and byte-enable (4 bytes) types.
    typedef logic [4:0] reg_addr_t;
    typedef logic [3:0] byte_en_t;

endpackage : Global

// File: rtl/rf_scoreboard.sv
// Per-entry pending scoreboard: issue sets a bit, writeback clears it, and a registered popcount is kept.
// Latency: bits and pending_cnt update on the rising edge after issue/writeback; pending_vec is the registered state.
// Backpressure: none; every issue/writeback is accepted in the cycle it is presented.
// Ports: clk, rst (async active-high), issue_en/issue_addr (set), we/wa (clear), pending_vec, pending_cnt.
module rf_scoreboard
    import Global::*;
#(
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    output logic [DEPTH-1:0] pending_vec,
    output logic [AW:0]      pending_cnt
);

    logic [DEPTH-1:0] pending_d, pending_q;
    logic [AW:0]      cnt_d, cnt_q;

    always_comb begin
        pending_d = pending_q;
        // Clear first, then set: an issue and a writeback to the same entry in
        // one cycle leave it pending, because the new producer is still in flight.
        if (we) begin
            pending_d[wa] = 1'b0;
        end
        if (issue_en) begin
            pending_d[issue_addr] = 1'b1;
        end
        // The hardwired zero entry never waits on a producer.
        if (ZERO_REG != 0) begin
            pending_d[0] = 1'b0;
        end

        // Count from the next-state vector so the count moves on the same edge as the bits.
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + (AW+1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_vec = pending_q;
    assign pending_cnt = cnt_q;

endmodule : rf_scoreboard

// File: rtl/reg_file_sb.sv
// Multi-entry register file: 2 combinational read ports, 1 byte-maskable write port with bypass, pending scoreboard.
// Latency: reads are 0 cycles (same-cycle write is forwarded); writes and scoreboard update on the rising edge.
// Backpressure: none; busy1/busy2 let issue logic stall on entries still awaiting writeback.
// Ports: clk, rst, ra1/rd1/busy1, ra2/rd2/busy2, we/wa/wd/wbe, issue_en/issue_addr, pending_cnt.
module reg_file_sb
    import Global::*;
#(
    parameter  int WIDTH    = int'(size_t),
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      ra1,
    output logic [WIDTH-1:0]   rd1,
    output logic               busy1,
    input  logic [AW-1:0]      ra2,
    output logic [WIDTH-1:0]   rd2,
    output logic               busy2,
    input  logic               we,
    input  logic [AW-1:0]      wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic               issue_en,
    input  logic [AW-1:0]      issue_addr,
    output logic [AW:0]        pending_cnt
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] wr_merged;
    logic             wr_to_zero;
    logic [DEPTH-1:0] pending_vec;

    // Value entry wa takes after this cycle's write: new bytes where enabled, old bytes elsewhere.
    always_comb begin
        wr_merged = mem_q[wa];
        for (int i = 0; i < NB; i++) begin
            if (wbe[i]) begin
                wr_merged[8*i +: 8] = wd[8*i +: 8];
            end
        end
    end

    assign wr_to_zero = (ZERO_REG != 0) && (wa == '0);

    always_comb begin
        mem_d = mem_q;
        if (we && !wr_to_zero) begin
            mem_d[wa] = wr_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read path: the zero entry wins over bypass, bypass wins over storage.
    always_comb begin
        if ((ZERO_REG != 0) && (ra1 == '0)) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wr_merged;
        end else begin
            rd1 = mem_q[ra1];
        end

        if ((ZERO_REG != 0) && (ra2 == '0)) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wr_merged;
        end else begin
            rd2 = mem_q[ra2];
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .we          (we),
        .wa          (wa),
        .pending_vec (pending_vec),
        .pending_cnt (pending_cnt)
    );

    // The writeback cycle itself is not busy: its data is already on the bypass.
    // A same-cycle issue only shows up once the pending bit is registered.
    assign busy1 = pending_vec[ra1] & ~(we && (wa == ra1));
    assign busy2 = pending_vec[ra2] & ~(we && (wa == ra2));

endmodule : reg_file_sb
